trace_frame_serializer: RTL and testbench

//   Consumer end of the sentinel_shell trace stream. Accepts one trace record per valid/ready

---
 rtl/trace_frame_serializer_if.sv | 33 +++
 rtl/trace_frame_serializer.sv | 164 ++++++++++++++++
 tb/tb_trace_frame_serializer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_frame_serializer_if.sv
// Handshake bundle between a trace-record producer and the frame serializer:
// record stream in, 32-bit word stream out.
interface trace_frame_serializer_if #(
    parameter int TX_ID_WIDTH  = 32,
    parameter int CYCLE_WIDTH  = 48,
    parameter int OPCODE_WIDTH = 8,
    parameter int META_WIDTH   = 32
);
    logic                    trace_valid;
    logic                    trace_ready;
    logic [TX_ID_WIDTH-1:0]  trace_tx_id;
    logic [CYCLE_WIDTH-1:0]  trace_t_ingress;
    logic [CYCLE_WIDTH-1:0]  trace_t_egress;
    logic [15:0]             trace_flags;
    logic [OPCODE_WIDTH-1:0] trace_opcode;
    logic [META_WIDTH-1:0]   trace_meta;
    logic                    word_valid;
    logic                    word_ready;
    logic [31:0]             word_data;
    logic                    word_last;

    modport master (
        output trace_valid, trace_tx_id, trace_t_ingress, trace_t_egress,
               trace_flags, trace_opcode, trace_meta, word_ready,
        input  trace_ready, word_valid, word_data, word_last
    );

    modport slave (
        input  trace_valid, trace_tx_id, trace_t_ingress, trace_t_egress,
               trace_flags, trace_opcode, trace_meta, word_ready,
        output trace_ready, word_valid, word_data, word_last
    );
endinterface

// File: rtl/trace_frame_serializer.sv
// Serializes one trace record into a fixed frame of 32-bit words (W0..W8).
// Define TRACE_SER_CHECKSUM_EN to append W9 = XOR of W0..W8 as the last word.
module trace_frame_serializer #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         FRAME_GAP    = 0,
    parameter int         TX_ID_WIDTH  = 32,
    parameter int         CYCLE_WIDTH  = 48,
    parameter int         OPCODE_WIDTH = 8,
    parameter int         META_WIDTH   = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    trace_frame_serializer_if.slave        bus,
    output logic [31:0]                    frames_sent,
    output logic                           busy
);
    if (TX_ID_WIDTH > 64 || CYCLE_WIDTH > 64 || OPCODE_WIDTH > 16 || META_WIDTH > 32 ||
        FRAME_GAP < 0 || FRAME_GAP > 15) begin : g_param_check
        $error("trace_frame_serializer: parameter out of range");
    end

`ifdef TRACE_SER_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd9;
`else
    localparam logic [3:0] LAST_IDX = 4'd8;
`endif
    localparam logic [3:0] GAP_LOAD = (FRAME_GAP > 0) ? 4'(FRAME_GAP - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t      state_q;
    logic [3:0]  idx_q, gap_q;
    logic [7:0]  seq_q;
    logic [31:0] frames_q;
    logic [15:0] flags_q, opcode_q;
    logic [63:0] tx_id_q, t_in_q, t_eg_q;
    logic [31:0] meta_q;
    logic        word_valid_q, word_last_q;
    logic [31:0] word_data_q;
`ifdef TRACE_SER_CHECKSUM_EN
    logic [31:0] csum_q;
`endif

    logic [7:0]  seq_d;
    logic [31:0] frames_d;
    logic [3:0]  idx_d;
    logic        last_fire, accept;
    logic [31:0] w0_in, adv_word;

    function automatic logic [31:0] word_of(input logic [3:0] i, input logic [7:0] s,
                                            input logic [15:0] fl, input logic [63:0] tx,
                                            input logic [63:0] ti, input logic [63:0] te,
                                            input logic [15:0] op, input logic [31:0] mt);
        logic [31:0] w;
        case (i)
            4'd0:    w = {SYNC_BYTE, s, fl};
            4'd1:    w = tx[31:0];
            4'd2:    w = tx[63:32];
            4'd3:    w = ti[31:0];
            4'd4:    w = ti[63:32];
            4'd5:    w = te[31:0];
            4'd6:    w = te[63:32];
            4'd7:    w = {op, 16'h0000};
            default: w = mt;
        endcase
        return w;
    endfunction

    assign seq_d     = seq_q + 8'd1;
    assign frames_d  = (&frames_q) ? frames_q : frames_q + 32'd1;
    assign idx_d     = idx_q + 4'd1;
    assign last_fire = (state_q == SEND) && word_valid_q && bus.word_ready && (idx_q == LAST_IDX);

    // Ready is combinational on word_ready so a new record can be taken on the final word handshake.
    assign bus.trace_ready = rst_n && ((state_q == IDLE) || ((FRAME_GAP == 0) && last_fire));
    assign accept          = bus.trace_valid && bus.trace_ready;

    // A back-to-back capture happens while seq is being bumped, so its header takes the new value.
    assign w0_in = {SYNC_BYTE, (state_q == SEND) ? seq_d : seq_q, bus.trace_flags};

`ifdef TRACE_SER_CHECKSUM_EN
    assign adv_word = (idx_d == LAST_IDX) ? csum_q :
                      word_of(idx_d, seq_q, flags_q, tx_id_q, t_in_q, t_eg_q, opcode_q, meta_q);
`else
    assign adv_word = word_of(idx_d, seq_q, flags_q, tx_id_q, t_in_q, t_eg_q, opcode_q, meta_q);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= 4'd0;
            gap_q        <= 4'd0;
            seq_q        <= 8'd0;
            frames_q     <= 32'd0;
            flags_q      <= 16'd0;
            opcode_q     <= 16'd0;
            tx_id_q      <= 64'd0;
            t_in_q       <= 64'd0;
            t_eg_q       <= 64'd0;
            meta_q       <= 32'd0;
            word_valid_q <= 1'b0;
            word_last_q  <= 1'b0;
            word_data_q  <= 32'd0;
`ifdef TRACE_SER_CHECKSUM_EN
            csum_q       <= 32'd0;
`endif
        end else begin
            case (state_q)
                SEND: begin
                    if (bus.word_ready) begin
                        if (idx_q == LAST_IDX) begin
                            seq_q        <= seq_d;
                            frames_q     <= frames_d;
                            word_valid_q <= 1'b0;
                            word_last_q  <= 1'b0;
                            if (FRAME_GAP == 0) begin
                                state_q <= IDLE;
                            end else begin
                                state_q <= GAP;
                                gap_q   <= GAP_LOAD;
                            end
                        end else begin
                            idx_q       <= idx_d;
                            word_data_q <= adv_word;
                            word_last_q <= (idx_d == LAST_IDX);
`ifdef TRACE_SER_CHECKSUM_EN
                            csum_q      <= csum_q ^ adv_word;
`endif
                        end
                    end
                end
                GAP: begin
                    if (gap_q == 4'd0) state_q <= IDLE;
                    else               gap_q   <= gap_q - 4'd1;
                end
                default: state_q <= IDLE;
            endcase

            // Capture overrides the end-of-frame assignments above when records run back-to-back.
            if (accept) begin
                state_q      <= SEND;
                idx_q        <= 4'd0;
                flags_q      <= bus.trace_flags;
                opcode_q     <= 16'(bus.trace_opcode);
                tx_id_q      <= 64'(bus.trace_tx_id);
                t_in_q       <= 64'(bus.trace_t_ingress);
                t_eg_q       <= 64'(bus.trace_t_egress);
                meta_q       <= 32'(bus.trace_meta);
                word_valid_q <= 1'b1;
                word_last_q  <= 1'b0;
                word_data_q  <= w0_in;
`ifdef TRACE_SER_CHECKSUM_EN
                csum_q       <= w0_in;
`endif
            end
        end
    end

    assign bus.word_valid = word_valid_q;
    assign bus.word_data  = word_data_q;
    assign bus.word_last  = word_last_q;
    assign frames_sent    = frames_q;
    assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_trace_frame_serializer.sv
// Directed scoreboard bench: dut_a runs with FRAME_GAP=0, dut_b with FRAME_GAP=3.
module tb_trace_frame_serializer;
`ifdef TRACE_SER_CHECKSUM_EN
    localparam int NW = 10;
`else
    localparam int NW = 9;
`endif

    typedef struct {
        logic [31:0] tx;
        logic [47:0] ti;
        logic [47:0] te;
        logic [15:0] fl;
        logic [7:0]  op;
        logic [31:0] mt;
    } rec_t;
    typedef logic [32:0] frame_t [NW];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] frames_a, frames_b;
    logic        busy_a, busy_b;
    int          checks = 0;
    int          errors = 0;

    logic [32:0] exp_a[$];
    logic [32:0] exp_b[$];
    logic [7:0]  seq_a = 8'd0, seq_b = 8'd0;
    bit          toggle_a = 1'b0;

    logic        prev_v_a = 1'b0, prev_r_a = 1'b0, prev_l_a = 1'b0;
    logic [31:0] prev_d_a = 32'd0, last_hdr_a = 32'd0;
    int          widx_a = 0, run_a = 0, max_run_a = 0;
    bit          gap_on_b = 1'b0;
    int          gap_cnt_b = 0, gap_seen_b = -1;
    logic [32:0] e_a, e_b;

    trace_frame_serializer_if bus_a ();
    trace_frame_serializer_if bus_b ();

    trace_frame_serializer #(.FRAME_GAP(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .frames_sent(frames_a), .busy(busy_a));
    trace_frame_serializer #(.FRAME_GAP(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .frames_sent(frames_b), .busy(busy_b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic frame_t build(input rec_t r, input logic [7:0] s);
        frame_t f;
        logic [63:0] ti, te;
        logic [31:0] x;
        ti = 64'(r.ti);
        te = 64'(r.te);
        f[0] = {1'b0, 8'hA5, s, r.fl};
        f[1] = {1'b0, r.tx};
        f[2] = 33'd0;
        f[3] = {1'b0, ti[31:0]};
        f[4] = {1'b0, ti[63:32]};
        f[5] = {1'b0, te[31:0]};
        f[6] = {1'b0, te[63:32]};
        f[7] = {1'b0, 8'h00, r.op, 16'h0000};
        f[8] = {1'b0, r.mt};
`ifdef TRACE_SER_CHECKSUM_EN
        x = 32'd0;
        for (int i = 0; i < 9; i++) x = x ^ f[i][31:0];
        f[9] = {1'b1, x};
`else
        x = 32'd0;
        f[8][32] = 1'b1;
`endif
        return f;
    endfunction

    function automatic frame_t build_lit();
        frame_t f;
        f[0] = {1'b0, 32'hA5000003};
        f[1] = {1'b0, 32'h00000001};
        f[2] = {1'b0, 32'h00000000};
        f[3] = {1'b0, 32'h00000064};
        f[4] = {1'b0, 32'h00000000};
        f[5] = {1'b0, 32'h00000069};
        f[6] = {1'b0, 32'h00000000};
        f[7] = {1'b0, 32'h00120000};
`ifdef TRACE_SER_CHECKSUM_EN
        f[8] = {1'b0, 32'hDEADBEEF};
        f[9] = {1'b1, 32'h7BBFBEE0};
`else
        f[8] = {1'b1, 32'hDEADBEEF};
`endif
        return f;
    endfunction

    function automatic rec_t rnd_rec();
        rec_t r;
        r.tx = $urandom();
        r.ti = 48'({$urandom(), $urandom()});
        r.te = 48'({$urandom(), $urandom()});
        r.fl = 16'($urandom());
        r.op = 8'($urandom());
        r.mt = $urandom();
        return r;
    endfunction

    task automatic offer_a(input rec_t r, input bit lit);
        bit ok;
        frame_t f;
        ok = 1'b0;
        @(negedge clk);
        bus_a.trace_tx_id = r.tx; bus_a.trace_t_ingress = r.ti; bus_a.trace_t_egress = r.te;
        bus_a.trace_flags = r.fl; bus_a.trace_opcode = r.op; bus_a.trace_meta = r.mt;
        bus_a.trace_valid = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (bus_a.trace_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("accept_a", 64'(ok), 64'd1);
        if (ok) begin
            f = lit ? build_lit() : build(r, seq_a);
            for (int i = 0; i < NW; i++) exp_a.push_back(f[i]);
            seq_a = seq_a + 8'd1;
        end
        @(posedge clk); #1;
        bus_a.trace_valid = 1'b0;
        bus_a.trace_tx_id = $urandom(); bus_a.trace_meta = $urandom();
        bus_a.trace_flags = 16'($urandom()); bus_a.trace_opcode = 8'($urandom());
    endtask

    task automatic offer_b(input rec_t r);
        bit ok;
        frame_t f;
        ok = 1'b0;
        @(negedge clk);
        bus_b.trace_tx_id = r.tx; bus_b.trace_t_ingress = r.ti; bus_b.trace_t_egress = r.te;
        bus_b.trace_flags = r.fl; bus_b.trace_opcode = r.op; bus_b.trace_meta = r.mt;
        bus_b.trace_valid = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (bus_b.trace_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("accept_b", 64'(ok), 64'd1);
        if (ok) begin
            f = build(r, seq_b);
            for (int i = 0; i < NW; i++) exp_b.push_back(f[i]);
            seq_b = seq_b + 8'd1;
        end
        @(posedge clk); #1;
        bus_b.trace_valid = 1'b0;
        bus_b.trace_tx_id = $urandom(); bus_b.trace_meta = $urandom();
    endtask

    task automatic drain_a();
        int n;
        n = 0;
        while ((exp_a.size() != 0 || bus_a.word_valid) && n < 300) begin @(negedge clk); n++; end
        chk("drain_a", 64'(n < 300), 64'd1);
    endtask

    task automatic drain_b();
        int n;
        n = 0;
        while ((exp_b.size() != 0 || bus_b.word_valid) && n < 300) begin @(negedge clk); n++; end
        chk("drain_b", 64'(n < 300), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_a.delete(); exp_b.delete();
        seq_a = 8'd0; seq_b = 8'd0;
        rst_n = 1'b1;
    endtask

    // word_ready driver for dut_a: constant high or toggling every cycle.
    initial begin
        bus_a.word_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus_a.word_ready = toggle_a ? ~bus_a.word_ready : 1'b1;
        end
    end

    // Output monitor / scoreboard for both instances.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v_a = 1'b0; prev_r_a = 1'b0; widx_a = 0; run_a = 0;
            gap_on_b = 1'b0;
        end else begin
            if (prev_v_a && !prev_r_a) begin
                chk("stall_valid_a", 64'(bus_a.word_valid), 64'd1);
                chk("stall_data_a", 64'(bus_a.word_data), 64'(prev_d_a));
                chk("stall_last_a", 64'(bus_a.word_last), 64'(prev_l_a));
            end
            if (bus_a.word_valid) begin
                run_a++;
                if (run_a > max_run_a) max_run_a = run_a;
                chk("tready_in_send_a", 64'(bus_a.trace_ready),
                    64'(bus_a.word_last && bus_a.word_ready));
                if (bus_a.word_ready) begin
                    if (exp_a.size() == 0) begin
                        chk("unexpected_word_a", 64'(bus_a.word_data), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e_a = exp_a.pop_front();
                        chk("word_a", 64'({bus_a.word_last, bus_a.word_data}), 64'(e_a));
                        if (widx_a == 0) last_hdr_a = bus_a.word_data;
                        widx_a = bus_a.word_last ? 0 : widx_a + 1;
                    end
                end
            end else begin
                run_a = 0;
            end
            prev_v_a = bus_a.word_valid; prev_r_a = bus_a.word_ready;
            prev_d_a = bus_a.word_data;  prev_l_a = bus_a.word_last;

            if (bus_b.word_valid) begin
                chk("tready_in_send_b", 64'(bus_b.trace_ready), 64'd0);
                if (exp_b.size() == 0) begin
                    chk("unexpected_word_b", 64'(bus_b.word_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e_b = exp_b.pop_front();
                    chk("word_b", 64'({bus_b.word_last, bus_b.word_data}), 64'(e_b));
                end
            end
            if (bus_b.word_valid && bus_b.word_ready && bus_b.word_last) begin
                gap_on_b = 1'b1; gap_cnt_b = 0;
            end else if (gap_on_b) begin
                if (!bus_b.trace_ready && !bus_b.word_valid) gap_cnt_b++;
                else begin gap_on_b = 1'b0; gap_seen_b = gap_cnt_b; end
            end
        end
    end

    initial begin
        rec_t r1, r;
        r1.tx = 32'd1; r1.ti = 48'd100; r1.te = 48'd105;
        r1.fl = 16'h0003; r1.op = 8'h12; r1.mt = 32'hDEADBEEF;
        bus_a.trace_valid = 1'b0; bus_b.trace_valid = 1'b0; bus_b.word_ready = 1'b1;
        bus_a.trace_tx_id = '0; bus_a.trace_t_ingress = '0; bus_a.trace_t_egress = '0;
        bus_a.trace_flags = '0; bus_a.trace_opcode = '0; bus_a.trace_meta = '0;
        bus_b.trace_tx_id = '0; bus_b.trace_t_ingress = '0; bus_b.trace_t_egress = '0;
        bus_b.trace_flags = '0; bus_b.trace_opcode = '0; bus_b.trace_meta = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_word_valid", 64'(bus_a.word_valid), 64'd0);
        chk("rst_word_last", 64'(bus_a.word_last), 64'd0);
        chk("rst_word_data", 64'(bus_a.word_data), 64'd0);
        chk("rst_trace_ready", 64'(bus_a.trace_ready), 64'd0);
        chk("rst_frames", 64'(frames_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_trace_ready", 64'(bus_a.trace_ready), 64'd1);

        // Test 1: reference record, word_ready high
        offer_a(r1, 1'b1);
        drain_a();
        chk("t1_frames", 64'(frames_a), 64'd1);
        chk("t1_busy_idle", 64'(busy_a), 64'd0);

        // Test 2: same record with word_ready toggling
        toggle_a = 1'b1;
        offer_a(r1, 1'b0);
        drain_a();
        toggle_a = 1'b0;
        chk("t2_frames", 64'(frames_a), 64'd2);

        // Test 3: back-to-back records with no bubble
        do_reset();
        max_run_a = 0;
        offer_a(rnd_rec(), 1'b0);
        offer_a(rnd_rec(), 1'b0);
        drain_a();
        chk("t3_run_len", 64'(max_run_a), 64'(2 * NW));
        chk("t3_hdr2", 64'(last_hdr_a[31:16]), 64'h0000_0000_0000_A501);

        // Test 4: FRAME_GAP=3 instance
        offer_b(rnd_rec());
        offer_b(rnd_rec());
        drain_b();
        repeat (6) @(negedge clk);
        chk("t4_gap_len", 64'(gap_seen_b), 64'd3);
        chk("t4_frames_b", 64'(frames_b), 64'd2);

        // Test 5: seq wrap over 257 frames
        do_reset();
        for (int i = 0; i < 257; i++) offer_a(rnd_rec(), 1'b0);
        drain_a();
        chk("t5_frames", 64'(frames_a), 64'd257);
        chk("t5_seq_wrap", 64'(last_hdr_a[23:16]), 64'd0);

        // Reset while W4 is on the bus aborts the frame
        r = rnd_rec();
        offer_a(r, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_busy_mid", 64'(busy_a), 64'd1);
        chk("t5_w4_mid", 64'(bus_a.word_data), 64'(r.ti[47:32]));
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t5_abort_valid", 64'(bus_a.word_valid), 64'd0);
        chk("t5_abort_last", 64'(bus_a.word_last), 64'd0);
        chk("t5_abort_tready", 64'(bus_a.trace_ready), 64'd0);
        chk("t5_abort_frames", 64'(frames_a), 64'd0);
        exp_a.delete(); seq_a = 8'd0;
        rst_n = 1'b1;
        offer_a(rnd_rec(), 1'b0);
        drain_a();
        chk("t5_hdr_after_rst", 64'(last_hdr_a[31:16]), 64'h0000_0000_0000_A500);
        chk("t5_frames_after_rst", 64'(frames_a), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
